// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage of the 5-stage accumulator pipeline.
//
// Sits between the ID/EX and EX/MEM registers. Owns the architectural accumulator, so
// back-to-back accumulator ops see the updated value with no bubble. Both sides use
// valid/ready handshakes. Also provides flush, a sticky halt and an optional iterative
// shift-add multiplier.
//
// Optional feature macro: EX_MUL_EN
//   Defined:   opcode 12 (MUL) runs a DATA_W-cycle shift-add multiply.
//   Undefined: no multiplier logic is built, busy is tied to 0 and MUL acts as NOP.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush             kill the output stage and abort a multiply
//   in_valid/ready    ID/EX handshake; in_opcode, in_dest, in_imm, in_reg_val,
//                     in_reg_write, in_mem_write carry the entry
//   out_valid/ready   EX/MEM handshake; out_opcode, out_dest, out_reg_write,
//                     out_mem_write, alu_result, out_mem_data are registered
//   acc, carry        accumulator (forwarding source) and ADD/SUB/MUL carry
//   busy              multiplier in progress
//   halt              sticky halt, cleared only by reset
module ex_stage_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_reg_val,
    input  logic              in_reg_write,
    input  logic              in_mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_reg_write,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              busy,
    output logic              halt
);

    typedef enum logic [1:0] {StIdle, StMulBusy, StHalted} state_e;

    localparam logic [OP_W-1:0] OpNop = OP_W'(0);
    localparam logic [OP_W-1:0] OpLdo = OP_W'(1);
    localparam logic [OP_W-1:0] OpLda = OP_W'(2);
    localparam logic [OP_W-1:0] OpSto = OP_W'(3);
    localparam logic [OP_W-1:0] OpPre = OP_W'(4);
    localparam logic [OP_W-1:0] OpAdd = OP_W'(5);
    localparam logic [OP_W-1:0] OpLdm = OP_W'(6);
    localparam logic [OP_W-1:0] OpHlt = OP_W'(7);
    localparam logic [OP_W-1:0] OpSub = OP_W'(8);
    localparam logic [OP_W-1:0] OpAnd = OP_W'(9);
    localparam logic [OP_W-1:0] OpOr  = OP_W'(10);
    localparam logic [OP_W-1:0] OpXor = OP_W'(11);
`ifdef EX_MUL_EN
    localparam logic [OP_W-1:0] OpMul = OP_W'(12);
    localparam int unsigned     CntW  = $clog2(DATA_W + 1);
`endif

    state_e              state_q, state_d;
    logic                halt_q, halt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    logic                out_valid_q, out_valid_d;
    logic [OP_W-1:0]     out_opcode_q, out_opcode_d;
    logic [REG_AW-1:0]   out_dest_q, out_dest_d;
    logic                out_rw_q, out_rw_d;
    logic                out_mw_q, out_mw_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;

`ifdef EX_MUL_EN
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0]   mul_dest_q, mul_dest_d;
    logic                mul_rw_q, mul_rw_d;
    logic                mul_mw_q, mul_mw_d;
`endif

    // Single-cycle op decode, evaluated against the current accumulator.
    logic [DATA_W-1:0] op_res;
    logic [DATA_W-1:0] op_acc;
    logic              op_carry;
    logic [DATA_W-1:0] op_mem;
    logic              is_hlt;
    logic              is_mul;
    logic              accept;

    assign in_ready = (state_q == StIdle) && !halt_q && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_res   = acc_q;
        op_acc   = acc_q;
        op_carry = carry_q;
        op_mem   = '0;
        is_hlt   = 1'b0;
        is_mul   = 1'b0;
        case (in_opcode)
            OpNop, OpLdm: op_res = acc_q;
            OpLdo, OpLda: op_res = in_imm;
            OpSto: begin
                op_res = in_reg_val;
                op_mem = in_reg_val;
            end
            OpPre: begin
                op_acc = in_reg_val;
                op_res = in_reg_val;
            end
            OpAdd: begin
                {op_carry, op_acc} = {1'b0, acc_q} + {1'b0, in_reg_val};
                op_res             = op_acc;
            end
            OpSub: begin
                // Top bit of the widened difference is the borrow.
                {op_carry, op_acc} = {1'b0, acc_q} - {1'b0, in_reg_val};
                op_res             = op_acc;
            end
            OpAnd: begin
                op_acc = acc_q & in_reg_val;
                op_res = op_acc;
            end
            OpOr: begin
                op_acc = acc_q | in_reg_val;
                op_res = op_acc;
            end
            OpXor: begin
                op_acc = acc_q ^ in_reg_val;
                op_res = op_acc;
            end
            OpHlt: is_hlt = 1'b1;
`ifdef EX_MUL_EN
            OpMul: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        halt_d       = halt_q;
        acc_d        = acc_q;
        carry_d      = carry_q;
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_dest_d   = out_dest_q;
        out_rw_d     = out_rw_q;
        out_mw_d     = out_mw_q;
        alu_d        = alu_q;
        mem_data_d   = mem_data_q;
`ifdef EX_MUL_EN
        mcand_d      = mcand_q;
        prod_d       = prod_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        mul_dest_d   = mul_dest_q;
        mul_rw_d     = mul_rw_q;
        mul_mw_d     = mul_mw_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            // in_ready is already low, so no acceptance can race with this.
            out_valid_d = 1'b0;
            if (state_q == StMulBusy) begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && is_mul) begin
                        state_d = StMulBusy;
`ifdef EX_MUL_EN
                        mcand_d    = {{DATA_W{1'b0}}, acc_q};
                        mplier_d   = in_reg_val;
                        prod_d     = '0;
                        cnt_d      = '0;
                        mul_dest_d = in_dest;
                        mul_rw_d   = in_reg_write;
                        mul_mw_d   = in_mem_write;
`endif
                    end else if (accept) begin
                        out_valid_d  = 1'b1;
                        out_opcode_d = in_opcode;
                        out_dest_d   = in_dest;
                        out_rw_d     = in_reg_write;
                        out_mw_d     = in_mem_write;
                        alu_d        = op_res;
                        mem_data_d   = op_mem;
                        acc_d        = op_acc;
                        carry_d      = op_carry;
                        if (is_hlt) begin
                            halt_d  = 1'b1;
                            state_d = StHalted;
                        end
                    end
                end
                StMulBusy: begin
`ifdef EX_MUL_EN
                    if (cnt_q != CntW'(DATA_W)) begin
                        if (mplier_q[0]) begin
                            prod_d = prod_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + 1'b1;
                    end else if (!out_valid_q || out_ready) begin
                        // Product ready and the output register is free or draining.
                        out_valid_d  = 1'b1;
                        out_opcode_d = OpMul;
                        out_dest_d   = mul_dest_q;
                        out_rw_d     = mul_rw_q;
                        out_mw_d     = mul_mw_q;
                        alu_d        = prod_q[DATA_W-1:0];
                        mem_data_d   = '0;
                        acc_d        = prod_q[DATA_W-1:0];
                        carry_d      = |prod_q[2*DATA_W-1:DATA_W];
                        state_d      = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
                StHalted: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            halt_q       <= 1'b0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_dest_q   <= '0;
            out_rw_q     <= 1'b0;
            out_mw_q     <= 1'b0;
            alu_q        <= '0;
            mem_data_q   <= '0;
`ifdef EX_MUL_EN
            mcand_q      <= '0;
            prod_q       <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            mul_dest_q   <= '0;
            mul_rw_q     <= 1'b0;
            mul_mw_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            halt_q       <= halt_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_dest_q   <= out_dest_d;
            out_rw_q     <= out_rw_d;
            out_mw_q     <= out_mw_d;
            alu_q        <= alu_d;
            mem_data_q   <= mem_data_d;
`ifdef EX_MUL_EN
            mcand_q      <= mcand_d;
            prod_q       <= prod_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            mul_dest_q   <= mul_dest_d;
            mul_rw_q     <= mul_rw_d;
            mul_mw_q     <= mul_mw_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_dest      = out_dest_q;
    assign out_reg_write = out_rw_q;
    assign out_mem_write = out_mw_q;
    assign alu_result    = alu_q;
    assign out_mem_data  = mem_data_q;
    assign acc           = acc_q;
    assign carry         = carry_q;
    assign halt          = halt_q;
`ifdef EX_MUL_EN
    assign busy          = (state_q == StMulBusy);
`else
    assign busy          = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe (DATA_W=8, REG_AW=5, OP_W=4).
// Directed vector table, randomized traffic against a behavioural model, and
// hand-written sequences for stall, flush, multiply (when EX_MUL_EN) and halt/reset.
module tb_ex_stage_pipe;

    localparam int DW  = 8;
    localparam int MOD = 1 << DW;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [4:0] in_dest;
    logic [7:0] in_imm;
    logic [7:0] in_reg_val;
    logic       in_reg_write;
    logic       in_mem_write;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_opcode;
    logic [4:0] out_dest;
    logic       out_reg_write;
    logic       out_mem_write;
    logic [7:0] alu_result;
    logic [7:0] out_mem_data;
    logic [7:0] acc;
    logic       carry;
    logic       busy;
    logic       halt;

    ex_stage_pipe #(.DATA_W(8), .REG_AW(5), .OP_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_dest       (in_dest),
        .in_imm        (in_imm),
        .in_reg_val    (in_reg_val),
        .in_reg_write  (in_reg_write),
        .in_mem_write  (in_mem_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_dest      (out_dest),
        .out_reg_write (out_reg_write),
        .out_mem_write (out_mem_write),
        .alu_result    (alu_result),
        .out_mem_data  (out_mem_data),
        .acc           (acc),
        .carry         (carry),
        .busy          (busy),
        .halt          (halt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state.
    int m_acc, m_carry, m_res, m_mem, m_op, m_dest;
    bit m_ov;
    int lat;
    bit seen;

    typedef struct {
        logic [3:0] op;
        logic [7:0] rv;
        logic [7:0] imm;
        logic [7:0] res;
        logic [7:0] acc;
        logic       c;
        logic [7:0] mem;
    } vec_t;

    vec_t vecs [18];
    int   nvec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] rv,
                         input logic [7:0] im, input logic [4:0] d);
        in_valid     = v;
        in_opcode    = op;
        in_reg_val   = rv;
        in_imm       = im;
        in_dest      = d;
        in_reg_write = d[0];
        in_mem_write = d[1];
    endtask

    // Called just after a rising edge; pulses reset well away from the next edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b0;
        #2;
        rst       = 1'b1;
        m_acc     = 0;
        m_carry   = 0;
        m_ov      = 1'b0;
        tick();
    endtask

    // Spec-level opcode semantics on plain integers.
    function automatic void ref_op(input int op, input int a, input int c, input int r,
                                   input int im, output int res, output int mem,
                                   output int na, output int nc);
        na  = a;
        nc  = c;
        mem = 0;
        res = a;
        case (op)
            1, 2: res = im;
            3: begin res = r; mem = r; end
            4: begin na = r; res = r; end
            5: begin na = (a + r) % MOD; nc = ((a + r) >= MOD) ? 1 : 0; res = na; end
            8: begin na = (a - r + MOD) % MOD; nc = (a < r) ? 1 : 0; res = na; end
            9: begin na = a & r; res = na; end
            10: begin na = a | r; res = na; end
            11: begin na = a ^ r; res = na; end
            default: ;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int op, rv, im, d, na, nc;
        bit exp_ready, acc_ok;

        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 8'd0, 8'd0, 5'd0);

        // Reset values while reset is held.
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_acc", acc, 0);
        chk("rst_carry", carry, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halt", halt, 0);
        chk("rst_alu", alu_result, 0);
        chk("rst_mem", out_mem_data, 0);
        #1 rst = 1'b1;
        tick();

        // Directed vectors, applied back to back with out_ready held high.
        vecs[0]  = '{4'd4,  8'h10, 8'h00, 8'h10, 8'h10, 1'b0, 8'h00};
        vecs[1]  = '{4'd5,  8'h05, 8'h00, 8'h15, 8'h15, 1'b0, 8'h00};
        vecs[2]  = '{4'd4,  8'hF0, 8'h00, 8'hF0, 8'hF0, 1'b0, 8'h00};
        vecs[3]  = '{4'd5,  8'h20, 8'h00, 8'h10, 8'h10, 1'b1, 8'h00};
        vecs[4]  = '{4'd8,  8'h11, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h00};
        vecs[5]  = '{4'd8,  8'h0F, 8'h00, 8'hF0, 8'hF0, 1'b0, 8'h00};
        vecs[6]  = '{4'd9,  8'h3C, 8'h00, 8'h30, 8'h30, 1'b0, 8'h00};
        vecs[7]  = '{4'd10, 8'h05, 8'h00, 8'h35, 8'h35, 1'b0, 8'h00};
        vecs[8]  = '{4'd11, 8'hFF, 8'h00, 8'hCA, 8'hCA, 1'b0, 8'h00};
        vecs[9]  = '{4'd1,  8'h77, 8'h5A, 8'h5A, 8'hCA, 1'b0, 8'h00};
        vecs[10] = '{4'd2,  8'h13, 8'hA5, 8'hA5, 8'hCA, 1'b0, 8'h00};
        vecs[11] = '{4'd0,  8'h44, 8'h55, 8'hCA, 8'hCA, 1'b0, 8'h00};
        vecs[12] = '{4'd6,  8'h44, 8'h66, 8'hCA, 8'hCA, 1'b0, 8'h00};
        vecs[13] = '{4'd13, 8'h01, 8'h02, 8'hCA, 8'hCA, 1'b0, 8'h00};
        vecs[14] = '{4'd15, 8'hFF, 8'hFF, 8'hCA, 8'hCA, 1'b0, 8'h00};
        vecs[15] = '{4'd3,  8'hAB, 8'h11, 8'hAB, 8'hCA, 1'b0, 8'hAB};
        vecs[16] = '{4'd5,  8'h36, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
`ifdef EX_MUL_EN
        nvec = 17;
`else
        vecs[17] = '{4'd12, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
        nvec = 18;
`endif
        for (int i = 0; i < nvec; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].rv, vecs[i].imm, 5'(i));
            #1 chk("tbl_in_ready", in_ready, 1);
            tick();
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_alu", alu_result, vecs[i].res);
            chk("tbl_acc", acc, vecs[i].acc);
            chk("tbl_carry", carry, vecs[i].c);
            chk("tbl_mem", out_mem_data, vecs[i].mem);
            chk("tbl_opcode", out_opcode, vecs[i].op);
            chk("tbl_dest", out_dest, i);
            chk("tbl_reg_write", out_reg_write, i % 2);
            chk("tbl_mem_write", out_mem_write, (i / 2) % 2);
            chk("tbl_busy", busy, 0);
        end
        in_valid = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 7) op = 0;
`ifdef EX_MUL_EN
            if (op == 12) op = 5;
`endif
            rv = int'($urandom_range(0, 255));
            im = int'($urandom_range(0, 255));
            d  = int'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, 4'(op), 8'(rv), 8'(im), 5'(d));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            exp_ready = !flush && (!m_ov || out_ready);
            chk("rnd_in_ready", in_ready, exp_ready);
            acc_ok = in_valid && exp_ready;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (flush) begin
                m_ov = 1'b0;
            end else if (acc_ok) begin
                ref_op(op, m_acc, m_carry, rv, im, m_res, m_mem, na, nc);
                m_acc  = na;
                m_carry = nc;
                m_op   = op;
                m_dest = d;
                m_ov   = 1'b1;
            end
            tick();
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_acc", acc, m_acc);
            chk("rnd_carry", carry, m_carry);
            if (m_ov) begin
                chk("rnd_alu", alu_result, m_res);
                chk("rnd_mem", out_mem_data, m_mem);
                chk("rnd_opcode", out_opcode, m_op);
                chk("rnd_dest", out_dest, m_dest);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;

        // STO held under backpressure, then a queued ADD accepted when ready returns.
        do_reset();
        drive(1'b1, 4'd3, 8'hAB, 8'h00, 5'd2);
        out_ready = 1'b0;
        #1 chk("sto_in_ready", in_ready, 1);
        tick();
        drive(1'b1, 4'd5, 8'h01, 8'h00, 5'd3);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_alu", alu_result, 8'hAB);
            chk("stall_mem", out_mem_data, 8'hAB);
            chk("stall_acc", acc, 0);
        end
        out_ready = 1'b1;
        #1 chk("unstall_in_ready", in_ready, 1);
        tick();
        chk("unstall_alu", alu_result, 8'h01);
        chk("unstall_mem", out_mem_data, 0);
        chk("unstall_opcode", out_opcode, 5);
        in_valid = 1'b0;

        // Flush kills a stalled output and wins over a simultaneous acceptance.
        out_ready = 1'b0;
        tick();
        chk("pre_flush_valid", out_valid, 1);
        flush = 1'b1;
        drive(1'b1, 4'd4, 8'h77, 8'h00, 5'd0);
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_acc", acc, 8'h01);
        out_ready = 1'b1;

`ifdef EX_MUL_EN
        // 0x0C * 0x0B = 0x84 with DATA_W+1 accept-to-valid latency.
        drive(1'b1, 4'd4, 8'h0C, 8'h00, 5'd0);
        tick();
        drive(1'b1, 4'd12, 8'h0B, 8'h00, 5'd9);
        #1 chk("mul_accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        chk("mul_busy", busy, 1);
        chk("mul_in_ready", in_ready, 0);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (out_valid) lat = k;
        end
        chk("mul_latency", lat, 9);
        chk("mul_alu", alu_result, 8'h84);
        chk("mul_acc", acc, 8'h84);
        chk("mul_carry", carry, 0);
        chk("mul_dest", out_dest, 9);
        chk("mul_opcode", out_opcode, 12);
        chk("mul_busy_done", busy, 0);

        // Same multiply aborted by flush at cycle 4.
        drive(1'b1, 4'd4, 8'h0C, 8'h00, 5'd0);
        tick();
        drive(1'b1, 4'd12, 8'h0B, 8'h00, 5'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mulfl_busy", busy, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mulfl_no_valid", seen, 0);
        chk("mulfl_acc", acc, 8'h0C);
        chk("mulfl_in_ready", in_ready, 1);

        // 0x20 * 0x10 = 0x200: low byte 0, high half non-zero sets carry.
        drive(1'b1, 4'd4, 8'h20, 8'h00, 5'd0);
        tick();
        drive(1'b1, 4'd12, 8'h10, 8'h00, 5'd0);
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (out_valid) lat = k;
        end
        chk("mulc_latency", lat, 9);
        chk("mulc_acc", acc, 0);
        chk("mulc_carry", carry, 1);
`endif

        // HLT: sticky halt, drain stalled, then reset mid-stall.
        drive(1'b1, 4'd4, 8'h42, 8'h00, 5'd0);
        tick();
        drive(1'b1, 4'd7, 8'h00, 8'h00, 5'd3);
        #1 chk("hlt_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 4'd4, 8'h99, 8'h00, 5'd0);
        chk("hlt_halt", halt, 1);
        chk("hlt_out_valid", out_valid, 1);
        chk("hlt_alu", alu_result, 8'h42);
        chk("hlt_opcode", out_opcode, 7);
        for (int i = 0; i < 3; i++) begin
            #1 chk("halted_in_ready", in_ready, 0);
            tick();
            chk("halted_valid", out_valid, 1);
            chk("halted_acc", acc, 8'h42);
            chk("halted_halt", halt, 1);
        end
        out_ready = 1'b1;
        #1 chk("halted_ready_ignored", in_ready, 0);
        out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_halt", halt, 0);
        chk("midrst_acc", acc, 0);
        chk("midrst_alu", alu_result, 0);
        chk("midrst_opcode", out_opcode, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        tick();
        drive(1'b1, 4'd4, 8'h33, 8'h00, 5'd0);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_alu", alu_result, 8'h33);
        chk("post_rst_halt", halt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
